// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle shift-and-add multiplier that borrows the EX-stage ALU.
// In IDLE the EX operands and mode pass straight through to the ALU; during
// a multiply the ALU is driven with ADD steps and busy stalls the pipeline.
// The low 32 bits of the product are returned (same for signed/unsigned).
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   defined   -> RUN stops once the remaining multiplier bits are all zero,
//                and a zero multiplier skips RUN entirely.
//   undefined -> always 32 RUN iterations.
//
// ALU mode codes normally come from param.v; fallback values are provided
// here so the block also builds stand-alone.

`ifndef NOP_ALU
`define NOP_ALU 4'd0
`endif
`ifndef ADD
`define ADD 4'd1
`endif
`ifndef SUB
`define SUB 4'd2
`endif

module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_operandA,
  input  logic [31:0] ex_operandB,
  input  logic [3:0]  ex_ALU_mode,
  input  logic        mul_start,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [3:0]  alu_mode,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        mul_done,
  output logic [31:0] mul_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] acc_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [4:0]  count_reg;
  logic        busy_reg;
  logic        mul_done_reg;
  logic [31:0] mul_result_reg;

  logic [31:0] mplier_shifted;
  logic        last_iter;
  logic        skip_run;

  assign mplier_shifted = mplier_reg >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Stop as soon as no set multiplier bits remain; a zero multiplier never runs.
  assign last_iter = (count_reg == 5'd31) || (mplier_shifted == 32'd0);
  assign skip_run  = (mul_b == 32'd0);
`else
  assign last_iter = (count_reg == 5'd31);
  assign skip_run  = 1'b0;
`endif

  assign busy       = busy_reg;
  assign mul_done   = mul_done_reg;
  assign mul_result = mul_result_reg;

  // ALU port steering: pass-through in IDLE, ADD steps in RUN, NOP in DONE
  always_comb begin
    alu_operandA = ex_operandA;
    alu_operandB = ex_operandB;
    alu_mode     = ex_ALU_mode;
    case (state_reg)
      S_RUN: begin
        alu_operandA = acc_reg;
        alu_operandB = mplier_reg[0] ? mcand_reg : 32'd0;
        alu_mode     = `ADD;
      end
      S_DONE: begin
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_mode     = `NOP_ALU;
      end
      default: begin
      end
    endcase
  end

  // Sequencer FSM with datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      acc_reg        <= 32'd0;
      mcand_reg      <= 32'd0;
      mplier_reg     <= 32'd0;
      count_reg      <= 5'd0;
      busy_reg       <= 1'b0;
      mul_done_reg   <= 1'b0;
      mul_result_reg <= 32'd0;
    end else begin
      mul_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (mul_start) begin
            mcand_reg  <= mul_a;
            mplier_reg <= mul_b;
            acc_reg    <= 32'd0;
            count_reg  <= 5'd0;
            busy_reg   <= 1'b1;
            if (skip_run) begin
              // Zero multiplier: product is zero, report it next cycle.
              state_reg      <= S_DONE;
              mul_done_reg   <= 1'b1;
              mul_result_reg <= 32'd0;
            end else begin
              state_reg <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_reg    <= alu_result;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_shifted;
          count_reg  <= count_reg + 5'd1;
          if (last_iter) begin
            // The final sum is captured on entry to DONE so mul_result is
            // already valid in the cycle mul_done is high.
            state_reg      <= S_DONE;
            mul_done_reg   <= 1'b1;
            mul_result_reg <= alu_result;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer
// Randomized self-checking bench for alu_mul_sequencer. The bench plays the
// ALU (combinational ADD/SUB model) and predicts every observable value from
// plain arithmetic: product = a*b mod 2^32, done cycle from the multiplier,
// partial sums from the multiplier bits consumed so far.

`ifndef NOP_ALU
`define NOP_ALU 4'd0
`endif
`ifndef ADD
`define ADD 4'd1
`endif
`ifndef SUB
`define SUB 4'd2
`endif

module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] ex_operandA;
  logic [31:0] ex_operandB;
  logic [3:0]  ex_ALU_mode;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [3:0]  alu_mode;
  logic [31:0] alu_result;
  logic        busy;
  logic        mul_done;
  logic [31:0] mul_result;

  int checks   = 0;
  int failures = 0;

  alu_mul_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_operandA  (ex_operandA),
    .ex_operandB  (ex_operandB),
    .ex_ALU_mode  (ex_ALU_mode),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_mode     (alu_mode),
    .alu_result   (alu_result),
    .busy         (busy),
    .mul_done     (mul_done),
    .mul_result   (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU the sequencer borrows
  always_comb begin
    case (alu_mode)
      `ADD:    alu_result = alu_operandA + alu_operandB;
      `SUB:    alu_result = alu_operandA - alu_operandB;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cycle (counted from the accepting edge) in which mul_done is expected
  function automatic int exp_done_cycle(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int hi;
    hi = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return (b == 32'd0) ? 1 : hi + 2;
`else
    return 33;
`endif
  endfunction

  task automatic drive_ex_random();
    ex_operandA = $urandom;
    ex_operandB = $urandom;
    ex_ALU_mode = 4'($urandom_range(0, 15));
  endtask

  task automatic check_passthrough(input string tag);
    check({tag, "_pt_a"}, alu_operandA, ex_operandA);
    check({tag, "_pt_b"}, alu_operandB, ex_operandB);
    check({tag, "_pt_mode"}, {28'd0, alu_mode}, {28'd0, ex_ALU_mode});
  endtask

  // One multiply transaction; an extra start (ia, ib) is offered in cycle icyc
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input int icyc, input logic [31:0] ia, input logic [31:0] ib);
    int          lat;
    int          done_cnt;
    logic [31:0] prod;
    logic [31:0] mask;
    logic [31:0] partial;
    lat      = exp_done_cycle(b);
    prod     = a * b;
    done_cnt = 0;
    @(negedge clk);
    mul_start = 1'b1;
    mul_a     = a;
    mul_b     = b;
    @(posedge clk);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      drive_ex_random();
      mul_start = (k == icyc);
      mul_a     = (k == icyc) ? ia : $urandom;
      mul_b     = (k == icyc) ? ib : $urandom;
      #1;
      if (mul_done) done_cnt++;
      check("busy", {31'd0, busy}, {31'd0, (k <= lat)});
      check("mul_done", {31'd0, mul_done}, {31'd0, (k == lat)});
      if (k < lat) begin
        mask    = (k == 1) ? 32'd0 : 32'((64'd1 << (k - 1)) - 64'd1);
        partial = a * (b & mask);
        check("run_mode", {28'd0, alu_mode}, {28'd0, `ADD});
        check("run_acc", alu_operandA, partial);
        check("run_addend", alu_operandB, b[k-1] ? (a << (k - 1)) : 32'd0);
      end else if (k == lat) begin
        check("result", mul_result, prod);
        check("done_mode", {28'd0, alu_mode}, {28'd0, `NOP_ALU});
        check("done_a", alu_operandA, 32'd0);
        check("done_b", alu_operandB, 32'd0);
      end else begin
        check("result_hold", mul_result, prod);
        check_passthrough("idle");
      end
    end
    mul_start = 1'b0;
    check("done_count", done_cnt, 1);
    $display("mul a=%h b=%h result=%h expected=%h done_cycle=%0d",
             a, b, mul_result, prod, lat);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          saw_done;

    rst_n       = 1'b0;
    mul_start   = 1'b0;
    mul_a       = 32'd0;
    mul_b       = 32'd0;
    ex_operandA = 32'd0;
    ex_operandB = 32'd0;
    ex_ALU_mode = `NOP_ALU;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, mul_done}, 32'd0);
    check("rst_result", mul_result, 32'd0);
    rst_n = 1'b1;

    // Pass-through in IDLE, zero latency
    @(negedge clk);
    ex_operandA = 32'd5;
    ex_operandB = 32'd9;
    ex_ALU_mode = `SUB;
    #1;
    check_passthrough("ex_sub");
    check("pt_busy", {31'd0, busy}, 32'd0);
    check("pt_alu", alu_result, 32'hFFFF_FFFC);

    // Directed multiplies
    run_mul(32'd7, 32'd6, 0, 32'd0, 32'd0);
    run_mul(32'hFFFF_FFFF, 32'd2, 0, 32'd0, 32'd0);
    run_mul(32'hFFFF_FFFD, 32'd5, 0, 32'd0, 32'd0);
    run_mul(32'h1234_5678, 32'h8765_4321, 10, 32'd3, 32'd3);
    run_mul(32'd5, 32'd3, 0, 32'd0, 32'd0);
    run_mul(32'hDEAD_BEEF, 32'd0, 0, 32'd0, 32'd0);
    run_mul(32'd1, 32'h8000_0000, 0, 32'd0, 32'd0);
    // Start offered in the DONE cycle must be ignored
    run_mul(32'd11, 32'd13, exp_done_cycle(32'd13), 32'd2, 32'd2);

    // Randomized operands, with a spread of multiplier widths
    for (int t = 0; t < 16; t++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (t % 4 == 0) rb = 32'd0;
      run_mul(ra, rb, (t % 3 == 0) ? $urandom_range(1, 12) : 0, $urandom, $urandom);
    end

    // Reset during RUN aborts the multiply
    @(negedge clk);
    mul_start = 1'b1;
    mul_a     = 32'd9;
    mul_b     = 32'h8000_0003;
    @(posedge clk);
    saw_done = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      mul_start = 1'b0;
      #1;
      if (mul_done) saw_done++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_ex_random();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, mul_done}, 32'd0);
    check("abort_result", mul_result, 32'd0);
    check_passthrough("abort");
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      #1;
      if (mul_done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    $display("abort a=%h b=%h result=%h", 32'd9, 32'h8000_0003, mul_result);

    // Fresh multiply after the abort
    run_mul(32'd6, 32'd7, 0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
